// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Request-side partner of the decode-stage control unit. The external
// interrupt pin is synchronised and its rising edges are counted into a small
// pending queue. When the controller is idle, enabled, and the control unit is
// quiet, it raises `interrupt` for exactly one cycle per queued edge. It then
// follows the control unit's PUSH_FLAGS/PUSH_1 sequence and stays in the ISR
// until RETI completes, so interrupts never nest.
//
// Handshake with the control unit:
//   `interrupt` is a one-cycle request that the control unit always accepts in
//   the same cycle, because interrupt outranks RET/RETI/CALL. There is no
//   ready signal. The acknowledge is observed through `inter_state`:
//   PUSH_1 (2'b10) marks the end of the push sequence. `reti_done` closes the
//   service window, and is ignored unless the controller is in the ISR.
//
// Parameters:
//   SYNC_STAGES  flops in the int_pin synchroniser (must be >= 2)
//   MAX_PENDING  maximum number of queued, unissued edges
//
// Ports:
//   clk          processor clock, rising-edge active
//   rst          asynchronous active-high reset
//   int_pin      external interrupt line, asynchronous to clk
//   int_enable   global enable; when low, issue is blocked but edges still queue
//   cu_busy      control unit is mid-sequence (RET/RETI/CALL)
//   inter_state  control unit's registered interrupt state
//                (00 NO_INTERRUPT, 01 PUSH_FLAGS, 10 PUSH_1)
//   reti_done    one-cycle pulse as the RETI sequence completes
//   interrupt    one-cycle request to the control unit
//   in_isr       high from the end of the push sequence until reti_done
//   pending_cnt  queued, unissued edges
//   overflow     sticky; an edge arrived while the queue was full
//
// The FSM state is kept in the signal `state` so that checkers can bind to it:
//   ST_IDLE 0, ST_REQ 1, ST_PUSHING 2, ST_ISR 3.
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PENDING = 3,
  localparam int CNT_W = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             int_pin,
  input  logic             int_enable,
  input  logic             cu_busy,
  input  logic [1:0]       inter_state,
  input  logic             reti_done,
  output logic             interrupt,
  output logic             in_isr,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             overflow
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_PUSHING = 2'd2;
  localparam logic [1:0] ST_ISR     = 2'd3;

  // Control unit inter_state values this block reacts to
  localparam logic [1:0] IS_NO_INTERRUPT = 2'b00;
  localparam logic [1:0] IS_PUSH_1       = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // ---------------------------------------------------------------------------
  // Synchroniser and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_last;
  logic                   prev_q;
  logic                   edge_det;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], int_pin};
      prev_q <= sync_last;
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // A pin held high yields one edge: prev_q catches up one cycle later.
  assign edge_det = sync_last & ~prev_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic [1:0] state;
  logic [1:0] state_next;
  logic       issue;

  // The request is only launched when the control unit is completely quiet.
  // Any in-flight RET/RETI/CALL or an unfinished push holds it off.
  assign issue = (state == ST_IDLE)
               & (pending_cnt != CNT_ZERO)
               & int_enable
               & ~cu_busy
               & (inter_state == IS_NO_INTERRUPT);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (issue) begin
          state_next = ST_REQ;
        end
      end
      // The control unit always takes the request in the REQ cycle.
      ST_REQ: begin
        state_next = ST_PUSHING;
      end
      ST_PUSHING: begin
        if (inter_state == IS_PUSH_1) begin
          state_next = ST_ISR;
        end
      end
      ST_ISR: begin
        if (reti_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The outputs are registered from the next-state value, so each one is a
  // glitch-free flop that matches the state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
      in_isr    <= 1'b0;
    end else begin
      state     <= state_next;
      interrupt <= (state_next == ST_REQ);
      in_isr    <= (state_next == ST_ISR);
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-edge counter and sticky overflow
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  // If an edge and an issue land in the same cycle, they cancel. This is true
  // even at saturation, because the issue frees the slot the edge needs.
  // The issue condition requires pending_cnt != 0, so the decrement cannot
  // underflow.
  always_comb begin
    cnt_next = pending_cnt;
    ovf_next = overflow;
    if (edge_det && !issue) begin
      if (pending_cnt == CNT_MAX) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = pending_cnt + CNT_ONE;
      end
    end else if (!edge_det && issue) begin
      cnt_next = pending_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_cnt <= CNT_ZERO;
      overflow    <= 1'b0;
    end else begin
      pending_cnt <= cnt_next;
      overflow    <= ovf_next;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Drives the interrupt_controller with directed scenarios and then random
// traffic. A small control-unit responder answers each request with
// PUSH_FLAGS, and after an optional hold, PUSH_1.
//
// A reference model tracks the pin sample history, the pending count, the
// overflow flag, and the service phase. Each time the model decides a request
// issues, it pushes that cycle's index into exp_q. A monitor pops an entry
// whenever the DUT raises `interrupt`. The outputs are also compared with the
// model every cycle.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

  localparam int S    = 2;
  localparam int MAXP = 3;
  localparam int CW   = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          int_pin;
  logic          int_enable;
  logic          cu_busy;
  logic [1:0]    inter_state;
  logic          reti_done;
  logic          interrupt;
  logic          in_isr;
  logic [CW-1:0] pending_cnt;
  logic          overflow;

  interrupt_controller #(
    .SYNC_STAGES(S),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .int_pin    (int_pin),
    .int_enable (int_enable),
    .cu_busy    (cu_busy),
    .inter_state(inter_state),
    .reti_done  (reti_done),
    .interrupt  (interrupt),
    .in_isr     (in_isr),
    .pending_cnt(pending_cnt),
    .overflow   (overflow)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  //   mode: 0 idle, 1 request, 2 pushing, 3 in service routine
  //   hist[j] is the pin sample taken j+1 clock edges ago. An edge reaches
  //   the counter S edges after the pin is first sampled high.
  // ---------------------------------------------------------------------------
  int          m_mode = 0;
  int          m_cnt  = 0;
  bit          m_ovf  = 1'b0;
  bit          hist[$];
  int unsigned cyc    = 0;
  bit          m_e;
  bit          m_go;
  int          m_nc;
  int          hold_cycles = 0;

  initial begin
    for (int i = 0; i <= S; i++) hist.push_back(1'b0);
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_mode = 0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        for (int i = 0; i <= S; i++) hist[i] = 1'b0;
      end else begin
        m_e  = hist[S-1] && !hist[S];
        m_go = (m_mode == 0) && (m_cnt != 0) && (int_enable == 1'b1) &&
               (cu_busy == 1'b0) && (inter_state == 2'b00);
        m_nc = m_cnt + (m_e ? 1 : 0) - (m_go ? 1 : 0);
        if (m_nc > MAXP) begin
          m_nc  = MAXP;
          m_ovf = 1'b1;
        end
        m_cnt = m_nc;
        case (m_mode)
          0: if (m_go) begin
               m_mode = 1;
               exp_q.push_back(32'(cyc));
             end
          1: m_mode = 2;
          2: if (inter_state == 2'b10) m_mode = 3;
          3: if (reti_done == 1'b1) m_mode = 0;
          default: m_mode = 0;
        endcase
        hist.push_front(int_pin);
        void'(hist.pop_back());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle output comparison against the model
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("interrupt",   32'(interrupt),   32'(m_mode == 1));
      check("in_isr",      32'(in_isr),      32'(m_mode == 3));
      check("pending_cnt", 32'(pending_cnt), 32'(m_cnt));
      check("overflow",    32'(overflow),    32'(m_ovf));
    end
  end

  // ---------------------------------------------------------------------------
  // Issue monitor: every DUT request must match a queued model issue
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (interrupt === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL issue_unexpected: interrupt high at cycle %0d, expected no issue", cyc);
        end else begin
          check("issue_cycle", 32'(cyc), exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control-unit responder: PUSH_FLAGS, optional hold, PUSH_1, then idle
  // ---------------------------------------------------------------------------
  int r_phase = 0;
  int r_wait  = 0;

  initial begin
    inter_state = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        inter_state = 2'b00;
        r_phase     = 0;
      end else begin
        case (r_phase)
          0: if (interrupt === 1'b1) begin
               inter_state = 2'b01;
               r_wait      = hold_cycles;
               r_phase     = 1;
             end
          1: if (r_wait > 0) begin
               r_wait--;
             end else begin
               inter_state = 2'b10;
               r_phase     = 2;
             end
          2: begin
               inter_state = 2'b00;
               r_phase     = 0;
             end
          default: r_phase = 0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all called when positioned at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_pin(input int hi, input int lo);
    int_pin = 1'b1;
    tick(hi);
    int_pin = 1'b0;
    tick(lo);
  endtask

  task automatic reti_pulse();
    reti_done = 1'b1;
    tick(1);
    reti_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst        = 1'b1;
    int_pin    = 1'b0;
    int_enable = 1'b0;
    cu_busy    = 1'b0;
    reti_done  = 1'b0;
    tick(3);
    check("reset_interrupt", 32'(interrupt),   32'd0);
    check("reset_in_isr",    32'(in_isr),      32'd0);
    check("reset_pending",   32'(pending_cnt), 32'd0);
    check("reset_overflow",  32'(overflow),    32'd0);
    rst        = 1'b0;
    int_enable = 1'b1;
    tick(1);

    // Basic latency: the pin is first sampled at edge k, and the request is
    // high in cycle k+3.
    int_pin = 1'b1;
    @(posedge clk); #1; check("t1_cnt_c0", 32'(pending_cnt), 32'd0);
    @(posedge clk); #1; check("t1_cnt_c1", 32'(pending_cnt), 32'd0);
    @(posedge clk); #1; check("t1_cnt_c2", 32'(pending_cnt), 32'd1);
                        check("t1_int_c2", 32'(interrupt),   32'd0);
    @(posedge clk); #1; check("t1_int_c3", 32'(interrupt),   32'd1);
                        check("t1_cnt_c3", 32'(pending_cnt), 32'd0);
    @(posedge clk); #1; check("t1_int_c4", 32'(interrupt),   32'd0);
    @(posedge clk); #1; check("t1_isr_c5", 32'(in_isr),      32'd1);
    tick(5);
    int_pin = 1'b0;
    tick(3);

    // Edges arriving in the ISR are queued, not issued.
    pulse_pin(3, 3);
    pulse_pin(3, 3);
    tick(3);
    check("t2_cnt",    32'(pending_cnt), 32'd2);
    check("t2_int",    32'(interrupt),   32'd0);
    check("t2_in_isr", 32'(in_isr),      32'd1);
    reti_pulse();
    @(posedge clk); #1;
    check("t2_reissue",  32'(interrupt),   32'd1);
    check("t2_cnt_after", 32'(pending_cnt), 32'd1);
    tick(6); reti_pulse();
    tick(6); reti_pulse();
    tick(4);

    // A busy control unit holds the request off.
    cu_busy = 1'b1;
    int_pin = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("t3_busy_hold", 32'(interrupt), 32'd0);
    end
    @(negedge clk);
    cu_busy = 1'b0;
    int_pin = 1'b0;
    @(posedge clk); #1;
    check("t3_issue", 32'(interrupt), 32'd1);
    tick(6); reti_pulse();
    tick(3);

    // Saturation and overflow, then reset while PUSHING.
    do_reset();
    int_enable  = 1'b0;
    hold_cycles = 4;
    repeat (5) pulse_pin(2, 2);
    tick(3);
    check("t4_cnt_sat", 32'(pending_cnt), 32'd3);
    check("t4_ovf",     32'(overflow),    32'd1);
    check("t4_no_int",  32'(interrupt),   32'd0);
    int_enable = 1'b1;
    @(posedge clk); #1;
    check("t4_issue",      32'(interrupt),   32'd1);
    check("t4_cnt_after",  32'(pending_cnt), 32'd2);
    check("t4_ovf_sticky", 32'(overflow),    32'd1);
    @(posedge clk); #3;
    check("t6_cnt_before", 32'(pending_cnt), 32'd2);
    rst = 1'b1;
    #1;
    check("t6_rst_int", 32'(interrupt),   32'd0);
    check("t6_rst_isr", 32'(in_isr),      32'd0);
    check("t6_rst_cnt", 32'(pending_cnt), 32'd0);
    check("t6_rst_ovf", 32'(overflow),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst         = 1'b0;
    hold_cycles = 0;

    // An edge and an issue in the same cycle cancel (1 -> 1).
    int_enable = 1'b0;
    pulse_pin(2, 4);
    check("t5_cnt_before", 32'(pending_cnt), 32'd1);
    int_pin = 1'b1;
    tick(2);
    int_enable = 1'b1;
    @(posedge clk); #1;
    check("t5_int",      32'(interrupt),   32'd1);
    check("t5_cnt_same", 32'(pending_cnt), 32'd1);
    @(negedge clk);
    int_pin = 1'b0;
    tick(6); reti_pulse();
    tick(6); reti_pulse();
    tick(4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) int_pin = ~int_pin;
      int_enable  = ($urandom_range(0, 7) != 0);
      cu_busy     = ($urandom_range(0, 3) == 0);
      reti_done   = ($urandom_range(0, 9) == 0);
      hold_cycles = $urandom_range(0, 2);
    end
    @(negedge clk);
    rst       = 1'b0;
    reti_done = 1'b0;
    tick(10);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Request-side partner of the decode-stage control unit. Synchronises the external interrupt pin and queues rising edges, then raises the one-cycle `interrupt` request.
- Tracks the control unit's PUSH_FLAGS/PUSH_1 acknowledge sequence. Holds further requests until RETI completes, so interrupts never nest.
- Sits between the processor top-level pin and the control unit's `interrupt` input; reads back the registered inter-state and a RETI-completion pulse.

Parameters:
- SYNC_STAGES, 2, number of flops in the int_pin synchroniser (minimum 2).
- MAX_PENDING, 3, maximum queued unserviced edges; counter width is clog2(MAX_PENDING+1).

Ports:
- clk  input  1  processor clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- int_pin  input  1  external interrupt line, asynchronous to clk.
- int_enable  input  1  global enable; 0 blocks issue but edges are still queued.
- cu_busy  input  1  control unit mid-sequence: any of ret_state, reti_state nonzero, or inst_before_call asserted.
- inter_state  input  2  control unit's registered interrupt state: 00 NO_INTERRUPT, 01 PUSH_FLAGS, 10 PUSH_1.
- reti_done  input  1  one-cycle pulse when the RETI sequence leaves NOP2_RETI.
- interrupt  output  1  request to the control unit; high exactly one cycle per serviced edge.
- in_isr  output  1  high from the end of the push sequence until reti_done.
- pending_cnt  output  clog2(MAX_PENDING+1)  queued, unissued edges.
- overflow  output  1  sticky; set when an edge arrives while pending_cnt==MAX_PENDING.

Behaviour:
- Reset (async, immediate):
  - all sync flops, the edge-history flop, pending_cnt and overflow are 0;
  - state is IDLE; interrupt=0, in_isr=0.
- Edge detect:
  - edge = sync_last & ~prev.
  - A pin rising before clock edge k gives edge=1 during cycle k+SYNC_STAGES-1..k+SYNC_STAGES.
  - A pin held high produces exactly one edge. Pulses shorter than one clock may be missed; this is permitted.
- pending_cnt, per cycle:
  - +1 on edge;
  - -1 on the IDLE->REQ transition;
  - unchanged if both occur in the same cycle;
  - saturates at MAX_PENDING; an edge at saturation is dropped and sets overflow.
  - overflow clears only on rst.
- FSM states: IDLE, REQ, PUSHING, ISR.
  - IDLE->REQ when pending_cnt!=0 & int_enable & ~cu_busy & inter_state==00.
  - REQ->PUSHING unconditionally after one cycle. The control unit gives interrupt priority over RET/RETI/CALL, so the request is always accepted that cycle.
  - PUSHING->ISR when inter_state==10 (PUSH_1 cycle observed).
  - ISR->IDLE on reti_done.
- Outputs:
  - interrupt = (state==REQ), registered Moore output.
  - in_isr = (state==ISR).
- Latency: from the first clk edge sampling int_pin high to interrupt high is SYNC_STAGES+1 cycles, i.e. 3 with defaults, when IDLE and ungated.
- Edges arriving in REQ/PUSHING/ISR are queued. After reti_done, the next request issues no earlier than the cycle following return to IDLE.
- A reti_done pulse outside ISR is ignored.
- Deassertion of int_enable while in REQ/PUSHING/ISR does not abort the sequence in progress.
- rst asserted mid-sequence returns to IDLE and discards pending edges. Reset of the control unit's state is the top level's responsibility.

Test Plan:
- Reset, then pin low->high held 10 cycles, int_enable=1, cu_busy=0 -> pending_cnt=1 at cycle 2, interrupt high only in cycle 3, pending_cnt=0. Model inter_state 01 then 10 -> in_isr=1 the cycle after 10.
- In ISR, pulse pin twice (each 3 cycles high, 3 low) -> pending_cnt=2, interrupt stays 0. Pulse reti_done -> IDLE, interrupt high next cycle, pending_cnt=1.
- Edge while cu_busy=1 for 6 cycles -> interrupt held 0 throughout. Issued the cycle after cu_busy falls, provided inter_state==00.
- 5 edges with int_enable=0 and MAX_PENDING=3 -> pending_cnt=3, overflow=1. Set int_enable=1 -> interrupt issued, pending_cnt=2, overflow remains 1.
- Edge and IDLE->REQ transition in the same cycle -> pending_cnt unchanged (1->1).
- Assert rst while in PUSHING with pending_cnt=2 -> interrupt=0, in_isr=0, pending_cnt=0, overflow=0 immediately, before the next clk edge.
